// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// The master side issues requests and consumes results; the slave side is the sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies a variable shift as power-of-two constant stages, one per cycle.
// Optional macro SHIFT_SEQ_ROTATE_EN enables op 11 as rotate-right; otherwise op 11 echoes the operand.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AW-1:0] WMOD = AW'(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work;
    logic [AW-1:0]    amt_rem;
    logic [1:0]       op_q;
    logic             sign_q;
    logic             ovr_q;
    logic [WIDTH-1:0] out_q;

    logic [AW-1:0]    acc_amt;
    logic             acc_ovr;
    logic             acc_done;
    logic [AW-1:0]    low;
    logic [AW-1:0]    amt_step;
    logic [WIDTH-1:0] work_step;
    logic [WIDTH-1:0] fill;

    // One constant stage: sel is one-hot, selecting a shift distance of 2^i.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [AW-1:0]    sel,
        input logic [1:0]       op
    );
        logic signed [WIDTH-1:0] ds;
        logic        [WIDTH-1:0] r;
        ds = $signed(d);
        r  = d;
        for (int i = 0; i < AW; i++) begin
            if (sel[i] && ((1 << i) < WIDTH)) begin
                case (op)
                    2'b00:   r = d << (1 << i);
                    2'b01:   r = d >> (1 << i);
                    2'b10:   r = ds >>> (1 << i);
                    default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
                        r = (d >> (1 << i)) | (d << (WIDTH - (1 << i)));
`else
                        r = d;
`endif
                    end
                endcase
            end
        end
        return r;
    endfunction

    // Request decode at accept: effective amount, over-range flag, and zero-work shortcut.
    always_comb begin
        acc_amt = bus.in_amt;
        acc_ovr = (bus.in_amt >= WMOD);
        if (bus.in_op == 2'b11) begin
`ifdef SHIFT_SEQ_ROTATE_EN
            acc_amt = bus.in_amt % WMOD;
`else
            acc_amt = '0;
`endif
            acc_ovr = 1'b0;
        end
        acc_done = (acc_amt == '0);
    end

    // One SHIFT step: lowest set bit of the remaining amount, or a full fill when over-range.
    always_comb begin
        low       = amt_rem & (~amt_rem + AW'(1));
        fill      = {WIDTH{sign_q & (op_q == 2'b10)}};
        work_step = ovr_q ? fill : shift_stage(work, low, op_q);
        amt_step  = ovr_q ? '0 : (amt_rem & ~low);
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = acc_done ? DONE : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (amt_step == '0) state_nxt = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_data = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.in_valid && acc_done)
                out_q <= bus.in_data;
            else if (state == SHIFT && amt_step == '0)
                out_q <= work_step;
        end
    end

    // Working datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            work    <= bus.in_data;
            amt_rem <= acc_amt;
            op_q    <= bus.in_op;
            sign_q  <= bus.in_data[WIDTH-1];
            ovr_q   <= acc_ovr;
        end else if (state == SHIFT) begin
            work    <= work_step;
            amt_rem <= amt_step;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer (WIDTH=4, AW=3).
module tb_shift_sequencer;

    logic clk;
    logic rst;
    logic busy;
    int   total;
    int   bad;

    shift_sequencer_if #(.WIDTH(4), .AW(3)) bus();

    shift_sequencer #(.WIDTH(4), .AW(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, then wait (bounded) for out_valid while out_ready stays low.
    task automatic do_req(input logic [3:0] d, input logic [2:0] a, input logic [1:0] o,
                          output int lat, output int busy_cnt, output bit rdy_low);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_op    = o;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat      = 1;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        rdy_low  = (bus.in_ready === 1'b0);
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== 4'b0000) begin bad++; $display("FAIL reset_out_data got=%b exp=0000", bus.out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sll();
        int lat, bc; bit rl;
        do_req(4'b0011, 3'd2, 2'b00, lat, bc, rl);
        total++; if (bus.out_data !== 4'b1100) begin bad++; $display("FAIL sll_data got=%b exp=1100", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL sll_latency got=%0d exp=2", lat); end
        total++; if (bc !== 2) begin bad++; $display("FAIL sll_busy_cycles got=%0d exp=2", bc); end
        total++; if (rl !== 1'b1) begin bad++; $display("FAIL sll_in_ready_low got=%b exp=1", rl); end
        pop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sll_busy_after got=%b exp=0", busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL sll_ready_after got=%b exp=1", bus.in_ready); end
        do_req(4'b0111, 3'd1, 2'b00, lat, bc, rl);
        total++; if (bus.out_data !== 4'b1110) begin bad++; $display("FAIL sll1_data got=%b exp=1110", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL sll1_latency got=%0d exp=2", lat); end
        pop();
    endtask

    task automatic test_sra();
        int lat, bc; bit rl;
        do_req(4'b1000, 3'd3, 2'b10, lat, bc, rl);
        total++; if (bus.out_data !== 4'b1111) begin bad++; $display("FAIL sra_data got=%b exp=1111", bus.out_data); end
        total++; if (lat !== 3) begin bad++; $display("FAIL sra_latency got=%0d exp=3", lat); end
        pop();
    endtask

    task automatic test_srl();
        int lat, bc; bit rl;
        do_req(4'b1011, 3'd3, 2'b01, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0001) begin bad++; $display("FAIL srl_data got=%b exp=0001", bus.out_data); end
        total++; if (lat !== 3) begin bad++; $display("FAIL srl_latency got=%0d exp=3", lat); end
        pop();
    endtask

    task automatic test_over_range();
        int lat, bc; bit rl;
        do_req(4'b1010, 3'd4, 2'b01, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0000) begin bad++; $display("FAIL ovr_srl_data got=%b exp=0000", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL ovr_srl_latency got=%0d exp=2", lat); end
        pop();
        do_req(4'b1010, 3'd6, 2'b10, lat, bc, rl);
        total++; if (bus.out_data !== 4'b1111) begin bad++; $display("FAIL ovr_sra_neg_data got=%b exp=1111", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL ovr_sra_neg_latency got=%0d exp=2", lat); end
        pop();
        do_req(4'b0110, 3'd7, 2'b10, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0000) begin bad++; $display("FAIL ovr_sra_pos_data got=%b exp=0000", bus.out_data); end
        pop();
        do_req(4'b0111, 3'd5, 2'b00, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0000) begin bad++; $display("FAIL ovr_sll_data got=%b exp=0000", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL ovr_sll_latency got=%0d exp=2", lat); end
        pop();
    endtask

    task automatic test_zero_amt();
        int lat, bc; bit rl;
        do_req(4'b0101, 3'd0, 2'b00, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0101) begin bad++; $display("FAIL zero_data got=%b exp=0101", bus.out_data); end
        total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        pop();
    endtask

    task automatic test_op11();
        int lat, bc; bit rl;
`ifdef SHIFT_SEQ_ROTATE_EN
        do_req(4'b0001, 3'd5, 2'b11, lat, bc, rl);
        total++; if (bus.out_data !== 4'b1000) begin bad++; $display("FAIL ror_data got=%b exp=1000", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL ror_latency got=%0d exp=2", lat); end
        pop();
        do_req(4'b0110, 3'd3, 2'b11, lat, bc, rl);
        total++; if (bus.out_data !== 4'b1100) begin bad++; $display("FAIL ror3_data got=%b exp=1100", bus.out_data); end
        total++; if (lat !== 3) begin bad++; $display("FAIL ror3_latency got=%0d exp=3", lat); end
        pop();
`else
        do_req(4'b0110, 3'd3, 2'b11, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0110) begin bad++; $display("FAIL reserved_data got=%b exp=0110", bus.out_data); end
        total++; if (lat !== 1) begin bad++; $display("FAIL reserved_latency got=%0d exp=1", lat); end
        pop();
`endif
    endtask

    task automatic test_hold();
        int lat, bc; bit rl;
        do_req(4'b0001, 3'd1, 2'b00, lat, bc, rl);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1111;
        bus.in_amt   = 3'd1;
        bus.in_op    = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.out_data !== 4'b0010) begin bad++; $display("FAIL hold_data[%0d] got=%b exp=0010", i, bus.out_data); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        pop();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_pop_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== 4'b0010) begin bad++; $display("FAIL hold_idle_data got=%b exp=0010", bus.out_data); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_not_latched got=%b exp=0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bc; bit rl;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1000;
        bus.in_amt   = 3'd3;
        bus.in_op    = 2'b10;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_shift_busy got=%b exp=1", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== 4'b0000) begin bad++; $display("FAIL mid_rst_out_data got=%b exp=0000", bus.out_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_no_partial got=%b exp=0", bus.out_valid); end
        do_req(4'b1100, 3'd1, 2'b01, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0110) begin bad++; $display("FAIL mid_rst_fresh_data got=%b exp=0110", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL mid_rst_fresh_latency got=%0d exp=2", lat); end
        pop();
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit rl;
        do_req(4'b1001, 3'd2, 2'b01, lat, bc, rl);
        total++; if (bus.out_data !== 4'b0010) begin bad++; $display("FAIL b2b_first got=%b exp=0010", bus.out_data); end
        pop();
        do_req(4'b1001, 3'd2, 2'b10, lat, bc, rl);
        total++; if (bus.out_data !== 4'b1110) begin bad++; $display("FAIL b2b_second got=%b exp=1110", bus.out_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=2", lat); end
        pop();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sll();
        test_sra();
        test_srl();
        test_over_range();
        test_zero_amt();
        test_op11();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
